ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard. It is the transmit side of the existing `ps2_keyboard` receive path. It shares the open-drain `ps2_clk`/`ps2_data` lines through drive-low enables resolved at the pad. It asserts `busy` so the top level can gate the receiver's `nextdata_n` handling while a command is in flight.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_sync_edge.sv | 24 ++
 rtl/ps2_host_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_host_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 types and constants for the host transmit path (and the receiver).
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK         = 8'hFA;

  // data(8) + parity + stop; the start bit is driven separately at the end of INHIBIT
  localparam int PS2_FRAME_BITS = 10;

  // Frame shifted LSB first: {stop=1, odd parity, data}
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// 3-flop synchronizer for a raw PS/2 line plus falling-edge detect.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic fall
);

  logic [2:0] sync_q, sync_d;

  // Shift the raw line in; [0] is the metastability-exposed flop
  always_comb sync_d = {sync_q[1:0], raw};

  // Idle PS/2 lines are high, so reset to 1s to avoid a spurious fall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 3'b111;
    else     sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign fall  = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives the open-drain lines through
// drive-low enables; the pad resolves each line as drv_low ? 1'b0 : 1'bz.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_drv_low,
  output logic       ps2_data_drv_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // INHIBIT spans one cycle fewer than the clock-low time; RELEASE supplies the last one
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    IDX_LAST = 4'(PS2_FRAME_BITS - 1);

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

  ps2_sync_edge u_sync_clk (
    .clk(clk), .rst(rst), .raw(ps2_clk), .level(clk_lvl), .fall(clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk(clk), .rst(rst), .raw(ps2_data), .level(data_lvl), .fall(data_fall_unused)
  );

  ps2_tx_state_t                state_q, state_d;
  logic [PS2_FRAME_BITS-1:0]    frame_q, frame_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [3:0]                   idx_q, idx_d;
  logic                         clk_drv_q, clk_drv_d;
  logic                         data_drv_q, data_drv_d;
  logic                         ack_bad_q, ack_bad_d;
  logic                         ready_q, ready_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;
  logic                         ack_err_q, ack_err_d;
  logic                         to_q, to_d;

  // Next-state and registered-output logic for the whole transfer
  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    clk_drv_d  = clk_drv_q;
    data_drv_d = data_drv_q;
    ack_bad_d  = ack_bad_q;
    done_d     = 1'b0;
    ack_err_d  = 1'b0;
    to_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          frame_d   = ps2_frame(tx_data);
          cnt_d     = '0;
          idx_d     = '0;
          ack_bad_d = 1'b0;
          clk_drv_d = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == INH_LAST) begin
          data_drv_d = 1'b1;  // start bit
          state_d    = RELEASE;
        end
      end
      RELEASE: begin
        clk_drv_d = 1'b0;
        cnt_d     = '0;
        state_d   = SHIFT;
      end
      SHIFT, ACK, WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        // Timeout takes priority over a coincident clock fall
        if (cnt_q == TO_LAST) begin
          clk_drv_d  = 1'b0;
          data_drv_d = 1'b0;
          to_d       = 1'b1;
          state_d    = IDLE;
        end else if (state_q == SHIFT) begin
          if (clk_fall) begin
            data_drv_d = ~frame_q[idx_q];
            idx_d      = idx_q + 1'b1;
            if (idx_q == IDX_LAST) state_d = ACK;
          end
        end else if (state_q == ACK) begin
          if (clk_fall) begin
            ack_bad_d = data_lvl;
            state_d   = WAIT_IDLE;
          end
        end else begin
          if (clk_lvl && data_lvl) begin
            done_d    = 1'b1;
            ack_err_d = ack_bad_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Ready is withheld during the completion-pulse cycle so a new accept
    // always follows the pulse by one cycle; busy is its complement.
    ready_d = (state_d == IDLE) && !done_d && !to_d;
    busy_d  = !ready_d;
  end

  // State and output registers; reset releases both lines immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      clk_drv_q  <= 1'b0;
      data_drv_q <= 1'b0;
      ack_bad_q  <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      clk_drv_q  <= clk_drv_d;
      data_drv_q <= data_drv_d;
      ack_bad_q  <= ack_bad_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ack_err_q  <= ack_err_d;
      to_q       <= to_d;
    end
  end

  assign tx_ready         = ready_q;
  assign busy             = busy_q;
  assign ps2_clk_drv_low  = clk_drv_q;
  assign ps2_data_drv_low = data_drv_q;
  assign done             = done_q;
  assign ack_err          = ack_err_q;
  assign timeout_err      = to_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on wired-AND lines.
module tb_ps2_host_tx;

  localparam int INH = 30;
  localparam int TMO = 1500;
  localparam int H   = 20;   // device half clock period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_err, timeout_err;
  logic       clk_drv_low, data_drv_low;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       line_clk, line_data;

  int total = 0;
  int bad   = 0;

  assign line_clk  = dev_clk  & ~clk_drv_low;
  assign line_data = dev_data & ~data_drv_low;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk(line_clk), .ps2_data(line_data),
    .ps2_clk_drv_low(clk_drv_low), .ps2_data_drv_low(data_drv_low),
    .busy(busy), .done(done), .ack_err(ack_err), .timeout_err(timeout_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: waits for the host to release the clock, clocks nfall edges,
  // samples data on each rising edge, and (if nfall > 10) runs the ack slot.
  task automatic dev_xfer(input bit do_ack, input int nfall, output logic [9:0] cap,
                          output bit ok, output int busy_lost);
    int n;
    cap = '0; ok = 1'b1; busy_lost = 0; n = 0;
    while (!clk_drv_low && n < 3000) begin @(negedge clk); n++; end
    while (clk_drv_low && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin ok = 1'b0; return; end
    if (line_data !== 1'b0) ok = 1'b0;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nfall && i < 10; i++) begin
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      cap[i] = line_data;
      if (!busy) busy_lost++;
      dev_clk = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (nfall > 10) begin
      if (do_ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      repeat (2) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    while (!(done || timeout_err) && n < 200) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++; if (clk_drv_low !== 1'b0 || data_drv_low !== 1'b0) begin bad++;
      $display("FAIL reset_drives: got %b%b want 00", clk_drv_low, data_drv_low); end
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_ready_busy: got %b%b want 10", tx_ready, busy); end
    total++; if (done !== 1'b0 || ack_err !== 1'b0 || timeout_err !== 1'b0) begin bad++;
      $display("FAIL reset_pulses: got %b%b%b want 000", done, ack_err, timeout_err); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++;
      $display("FAIL post_reset_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_set_led;
    logic [9:0] cap; bit ok; int bl, n, k;
    send(8'hED);
    total++; if (busy !== 1'b1 || clk_drv_low !== 1'b1) begin bad++;
      $display("FAIL accept_t1: got busy=%b clk_drv=%b want 11", busy, clk_drv_low); end
    fork
      dev_xfer(1'b1, 11, cap, ok, bl);
      begin
        k = 1;
        while (!data_drv_low && k < 200) begin @(negedge clk); k++; end
        total++; if (k != INH || clk_drv_low !== 1'b1) begin bad++;
          $display("FAIL start_bit_time: got %0d clk_drv=%b want %0d 1", k, clk_drv_low, INH); end
        @(negedge clk);
        total++; if (clk_drv_low !== 1'b0 || data_drv_low !== 1'b1) begin bad++;
          $display("FAIL clk_release: got %b%b want 01", clk_drv_low, data_drv_low); end
      end
    join
    total++; if (!ok || cap !== 10'h3ED) begin bad++;
      $display("FAIL ed_frame: got ok=%0d %h want 1 3ed", ok, cap); end
    wait_pulse(n);
    total++; if (done !== 1'b1 || ack_err !== 1'b0 || timeout_err !== 1'b0 || tx_ready !== 1'b0) begin bad++;
      $display("FAIL ed_done: got %b%b%b rdy=%b want 100 0", done, ack_err, timeout_err, tx_ready); end
    @(negedge clk);
    total++; if (done !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin bad++;
      $display("FAIL ed_after: got done=%b rdy=%b busy=%b want 010", done, tx_ready, busy); end
  endtask

  task automatic test_back_to_back;
    logic [9:0] cap; bit ok; int bl, n;
    send(8'hF4);
    dev_xfer(1'b1, 11, cap, ok, bl);
    total++; if (!ok || cap !== 10'h2F4 || bl != 0) begin bad++;
      $display("FAIL f4_frame: got ok=%0d %h busy_lost=%0d want 1 2f4 0", ok, cap, bl); end
    wait_pulse(n);
    total++; if (done !== 1'b1 || ack_err !== 1'b0) begin bad++;
      $display("FAIL f4_done: got %b%b want 10", done, ack_err); end
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++;
      $display("FAIL b2b_ready: got %b want 1", tx_ready); end
    tx_data = 8'h01; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL b2b_accept: got %b want 1", busy); end
    dev_xfer(1'b1, 11, cap, ok, bl);
    total++; if (!ok || cap !== 10'h201) begin bad++;
      $display("FAIL b2b_frame: got ok=%0d %h want 1 201", ok, cap); end
    wait_pulse(n);
    total++; if (done !== 1'b1 || ack_err !== 1'b0) begin bad++;
      $display("FAIL b2b_done: got %b%b want 10", done, ack_err); end
    @(negedge clk);
  endtask

  task automatic test_no_ack;
    logic [9:0] cap; bit ok; int bl, n;
    send(8'hF4);
    dev_xfer(1'b0, 11, cap, ok, bl);
    wait_pulse(n);
    total++; if (done !== 1'b1 || ack_err !== 1'b1 || timeout_err !== 1'b0) begin bad++;
      $display("FAIL noack_pulse: got %b%b%b want 110", done, ack_err, timeout_err); end
    total++; if (clk_drv_low !== 1'b0 || data_drv_low !== 1'b0) begin bad++;
      $display("FAIL noack_lines: got %b%b want 00", clk_drv_low, data_drv_low); end
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int k; bit saw_done;
    send(8'h12);
    k = 0;
    while (clk_drv_low && k < 200) begin @(negedge clk); k++; end
    k = 0; saw_done = 1'b0;
    while (!timeout_err && k < TMO + 50) begin
      @(negedge clk); k++;
      if (done) saw_done = 1'b1;
    end
    total++; if (k != TMO) begin bad++;
      $display("FAIL timeout_time: got %0d want %0d", k, TMO); end
    total++; if (clk_drv_low !== 1'b0 || data_drv_low !== 1'b0 || saw_done) begin bad++;
      $display("FAIL timeout_lines: got %b%b done=%b want 00 0", clk_drv_low, data_drv_low, saw_done); end
    @(negedge clk);
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin bad++;
      $display("FAIL timeout_idle: got rdy=%b busy=%b to=%b want 100", tx_ready, busy, timeout_err); end
  endtask

  task automatic test_reset_mid;
    logic [9:0] cap; bit ok; int bl, n;
    send(8'hED);
    dev_xfer(1'b1, 5, cap, ok, bl);
    // bit4 of 0xED is 0, so data is being pulled low after the 5th fall
    total++; if (busy !== 1'b1 || data_drv_low !== 1'b1) begin bad++;
      $display("FAIL mid_state: got busy=%b data_drv=%b want 11", busy, data_drv_low); end
    rst = 1'b1;
    #1;
    total++; if (clk_drv_low !== 1'b0 || data_drv_low !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin bad++;
      $display("FAIL mid_reset: got %b%b busy=%b rdy=%b want 00 0 1", clk_drv_low, data_drv_low, busy, tx_ready); end
    @(negedge clk);
    rst = 1'b0;
    send(8'hFF);
    dev_xfer(1'b1, 11, cap, ok, bl);
    total++; if (!ok || cap !== 10'h3FF) begin bad++;
      $display("FAIL ff_frame: got ok=%0d %h want 1 3ff", ok, cap); end
    wait_pulse(n);
    total++; if (done !== 1'b1 || ack_err !== 1'b0) begin bad++;
      $display("FAIL ff_done: got %b%b want 10", done, ack_err); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    logic [9:0] cap; bit ok; int bl, n;
    send(8'h55);
    fork
      dev_xfer(1'b1, 11, cap, ok, bl);
      begin
        repeat (5) @(negedge clk);
        tx_data = 8'hAA; tx_valid = 1'b1;
        total++; if (tx_ready !== 1'b0) begin bad++;
          $display("FAIL inhibit_ready: got %b want 0", tx_ready); end
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    total++; if (!ok || cap !== 10'h355) begin bad++;
      $display("FAIL ignore_frame: got ok=%0d %h want 1 355", ok, cap); end
    wait_pulse(n);
    total++; if (done !== 1'b1 || ack_err !== 1'b0) begin bad++;
      $display("FAIL ignore_done: got %b%b want 10", done, ack_err); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || clk_drv_low !== 1'b0) begin bad++;
      $display("FAIL ignore_no_requeue: got busy=%b clk_drv=%b want 00", busy, clk_drv_low); end
  endtask

  initial begin
    test_reset;
    test_set_led;
    test_back_to_back;
    test_no_ack;
    test_timeout;
    test_reset_mid;
    test_ignore_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
